// File: rtl/ipf_pkg.sv
// Shared types and constants for the IPF LCU feeder: frame geometry, LCU size
// encoding, parameter-word layout and the feeder state enum.
package ipf_pkg;

  localparam int IMG_W      = 128;
  localparam int RD_LAT     = 1;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    LCU_16   = 2'd0,
    LCU_32   = 2'd1,
    LCU_64   = 2'd2,
    LCU_RSVD = 2'd3
  } lcu_size_t;

  // Parameter word: {type, band_pos, wo_class, offset}
  localparam int PAR_TYPE_LSB = 22;
  localparam int PAR_TYPE_W   = 2;
  localparam int PAR_BAND_LSB = 17;
  localparam int PAR_BAND_W   = 5;
  localparam int PAR_WO_LSB   = 16;
  localparam int PAR_OFF_LSB  = 0;
  localparam int PAR_OFF_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PARAM  = 3'd1,
    ST_PLOAD  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DONE   = 3'd4
  } feeder_state_t;

  function automatic logic [6:0] lcu_dim(input logic [1:0] sz);
    return 7'd16 << sz;
  endfunction

  // Highest LCU coordinate per side (N-1).
  function automatic logic [2:0] lcu_last(input logic [1:0] sz);
    return 3'd7 >> sz;
  endfunction

  function automatic logic [12:0] lcu_pixels(input logic [1:0] sz);
    return 13'd256 << {sz, 1'b0};
  endfunction

endpackage

// File: rtl/ipf_pix_fifo.sv
// Two-entry 8-bit pixel FIFO between the image ROM return path and the IPF beat.
// Push and pop may happen together, including when full.
module ipf_pix_fifo
  import ipf_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic [1:0] count
);

  logic [7:0] mem [FIFO_DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= 8'd0;
      mem[1] <= 8'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/ipf_lcu_feeder.sv
// Streams a 128x128 frame from the image ROM to the IPF input port LCU by LCU,
// presenting each LCU's parameter word and coordinates alongside its pixels.
//
// state  | meaning
// IDLE   | waiting for start with a legal LCU size
// PARAM  | parameter ROM read for the current LCU
// PLOAD  | parameter word and coordinates registered onto the outputs
// STREAM | fetch and send the S*S pixels of the current LCU
// DONE   | one-cycle done pulse, back to IDLE
module ipf_lcu_feeder
  import ipf_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  cfg_lcu_size,
  output logic        img_rd,
  output logic [13:0] img_addr,
  input  logic [7:0]  img_data,
  output logic        par_rd,
  output logic [5:0]  par_addr,
  input  logic [23:0] par_data,
  input  logic        busy,
  output logic        in_en,
  output logic [7:0]  din,
  output logic [1:0]  ipf_type,
  output logic [4:0]  ipf_band_pos,
  output logic        ipf_wo_class,
  output logic [15:0] ipf_offset,
  output logic [2:0]  lcu_x,
  output logic [2:0]  lcu_y,
  output logic [1:0]  lcu_size,
  output logic        done
);

  feeder_state_t state, state_nx;
  logic [1:0]  sz;
  logic [2:0]  cx, cy, lcu_max;
  logic [5:0]  fr, fc, lcu_idx;
  logic [6:0]  s_dim;
  logic [12:0] fetch_left, beat_left;
  logic [13:0] row_pix, col_pix, pix_addr;
  logic [2:0]  fill;
  logic [1:0]  fifo_cnt;
  logic        inflight, pop, last_beat, last_lcu;

  assign s_dim     = lcu_dim(sz);
  assign lcu_max   = lcu_last(sz);
  assign lcu_idx   = ({3'b000, cy} << (2'd3 - sz)) + {3'b000, cx};
  assign row_pix   = 14'(cy) * 14'(s_dim) + 14'(fr);
  assign col_pix   = 14'(cx) * 14'(s_dim) + 14'(fc);
  assign pix_addr  = row_pix * 14'(IMG_W) + col_pix;

  assign in_en     = (state == ST_STREAM) && (fifo_cnt != 2'd0) && !busy;
  assign pop       = in_en;
  // Reads still in flight count as occupied so the FIFO can never overflow.
  assign fill      = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign img_rd    = (state == ST_STREAM) && (fetch_left != 13'd0) && (fill < 3'(FIFO_DEPTH));
  assign img_addr  = img_rd ? pix_addr : 14'd0;
  assign par_addr  = par_rd ? lcu_idx : 6'd0;
  assign last_beat = pop && (beat_left == 13'd1);
  assign last_lcu  = (cx == lcu_max) && (cy == lcu_max);

  ipf_pix_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (img_data),
    .pop       (pop),
    .head      (din),
    .count     (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    par_rd   = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE:   if (start && (cfg_lcu_size != LCU_RSVD)) state_nx = ST_PARAM;
      ST_PARAM: begin
        par_rd   = 1'b1;
        state_nx = ST_PLOAD;
      end
      ST_PLOAD:  state_nx = ST_STREAM;
      ST_STREAM: if (last_beat) state_nx = last_lcu ? ST_DONE : ST_PARAM;
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sz           <= 2'd0;
      cx           <= 3'd0;
      cy           <= 3'd0;
      fr           <= 6'd0;
      fc           <= 6'd0;
      fetch_left   <= 13'd0;
      beat_left    <= 13'd0;
      inflight     <= 1'b0;
      ipf_type     <= 2'd0;
      ipf_band_pos <= 5'd0;
      ipf_wo_class <= 1'b0;
      ipf_offset   <= 16'd0;
      lcu_x        <= 3'd0;
      lcu_y        <= 3'd0;
      lcu_size     <= 2'd0;
    end else begin
      inflight <= img_rd;
      case (state)
        ST_IDLE: if (start && (cfg_lcu_size != LCU_RSVD)) begin
          sz <= cfg_lcu_size;
          cx <= 3'd0;
          cy <= 3'd0;
          fr <= 6'd0;
          fc <= 6'd0;
        end
        ST_PLOAD: begin
          ipf_type     <= par_data[PAR_TYPE_LSB +: PAR_TYPE_W];
          ipf_band_pos <= par_data[PAR_BAND_LSB +: PAR_BAND_W];
          ipf_wo_class <= par_data[PAR_WO_LSB];
          ipf_offset   <= par_data[PAR_OFF_LSB +: PAR_OFF_W];
          lcu_x        <= cx;
          lcu_y        <= cy;
          lcu_size     <= sz;
          fetch_left   <= lcu_pixels(sz);
          beat_left    <= lcu_pixels(sz);
          fr           <= 6'd0;
          fc           <= 6'd0;
        end
        ST_STREAM: begin
          if (img_rd) begin
            fetch_left <= fetch_left - 13'd1;
            if ({1'b0, fc} == s_dim - 7'd1) begin
              fc <= 6'd0;
              fr <= fr + 6'd1;
            end else begin
              fc <= fc + 6'd1;
            end
          end
          if (pop) beat_left <= beat_left - 13'd1;
          if (last_beat) begin
            if (cx == lcu_max) begin
              cx <= 3'd0;
              cy <= cy + 3'd1;
            end else begin
              cx <= cx + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// Self-checking bench for ipf_lcu_feeder: ROM models, a beat monitor and a
// reference pixel/parameter order built from nested LCU/row/column loops.
module tb_ipf_lcu_feeder;

  logic        clk = 1'b0;
  logic        reset, start, busy;
  logic [1:0]  cfg_lcu_size;
  logic        img_rd, par_rd, in_en, done, ipf_wo_class;
  logic [13:0] img_addr;
  logic [7:0]  img_data, din;
  logic [5:0]  par_addr;
  logic [23:0] par_data;
  logic [1:0]  ipf_type, lcu_size;
  logic [4:0]  ipf_band_pos;
  logic [15:0] ipf_offset;
  logic [2:0]  lcu_x, lcu_y;

  always #5 clk = ~clk;

  ipf_lcu_feeder dut (
    .clk(clk), .reset(reset), .start(start), .cfg_lcu_size(cfg_lcu_size),
    .img_rd(img_rd), .img_addr(img_addr), .img_data(img_data),
    .par_rd(par_rd), .par_addr(par_addr), .par_data(par_data),
    .busy(busy), .in_en(in_en), .din(din),
    .ipf_type(ipf_type), .ipf_band_pos(ipf_band_pos), .ipf_wo_class(ipf_wo_class),
    .ipf_offset(ipf_offset), .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size),
    .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]  img_mem [16384];
  logic [23:0] par_mem [64];
  bit          ramp_mode;

  always @(posedge clk) cyc <= cyc + 1;

  // ROMs: one-cycle latency, junk on the bus when no read was issued.
  always @(posedge clk) begin
    img_data <= img_rd ? (ramp_mode ? img_addr[7:0] : img_mem[img_addr]) : 8'($urandom);
    par_data <= par_rd ? par_mem[par_addr] : 24'($urandom);
  end

  logic [7:0]  cap_din [$];
  int          cap_cyc [$];
  logic [23:0] cap_par [$];
  logic [7:0]  cap_pos [$];
  logic [5:0]  par_q   [$];
  int done_cnt, done_cyc, start_cyc, first_par_cyc, first_img_cyc;
  int busy_viol, img_rd_cnt, par_rd_cnt;

  always @(negedge clk) begin
    if (in_en) begin
      cap_din.push_back(din);
      cap_cyc.push_back(cyc);
      cap_par.push_back({ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset});
      cap_pos.push_back({lcu_size, lcu_y, lcu_x});
      if (busy) busy_viol++;
    end
    if (par_rd) begin
      if (par_rd_cnt == 0) first_par_cyc = cyc;
      par_rd_cnt++;
      par_q.push_back(par_addr);
    end
    if (img_rd) begin
      if (img_rd_cnt == 0) first_img_cyc = cyc;
      img_rd_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (start && start_cyc < 0) start_cyc = cyc;
  end

  function automatic int cyc_at(input int i);
    return (i < cap_cyc.size()) ? cap_cyc[i] : -1000;
  endfunction

  function automatic int din_at(input int i);
    return (i < cap_din.size()) ? int'(cap_din[i]) : -1;
  endfunction

  task automatic clear_mon();
    cap_din.delete(); cap_cyc.delete(); cap_par.delete(); cap_pos.delete(); par_q.delete();
    done_cnt = 0; done_cyc = -1; start_cyc = -1; first_par_cyc = -1; first_img_cyc = -1;
    busy_viol = 0; img_rd_cnt = 0; par_rd_cnt = 0;
  endtask

  task automatic pulse_start(input logic [1:0] sz);
    cfg_lcu_size = sz;
    @(posedge clk) #1 start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
  endtask

  task automatic run_frame(input int sz, input bit busy_rand, input int inject_beat, input int budget);
    bit injected = 1'b0;
    clear_mon();
    busy = 1'b0;
    pulse_start(2'(sz));
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      if (busy_rand) busy = 1'($urandom_range(0, 1));
      start = 1'b0;
      if (!injected && inject_beat >= 0 && cap_din.size() >= inject_beat) begin
        start = 1'b1;
        cfg_lcu_size = 2'd0;
        injected = 1'b1;
      end
      @(posedge clk) #1;
    end
    busy = 1'b0;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Compare captured beats with the raster-inside-LCU reference order.
  task automatic check_stream(input string nm, input int sz, input int nexp, input bit full);
    int n, s, idx;
    int md = 0, mp = 0, mc = 0, fd = -1, fp = -1, fc = -1;
    logic [13:0] a;
    logic [7:0]  ed, fd_got, fd_exp;
    logic [23:0] fp_got, fp_exp;
    logic [7:0]  ep, fc_got, fc_exp;
    n = 8 >> sz;
    s = 16 << sz;
    idx = 0;
    n_checks++;
    if (full ? (cap_din.size() != nexp) : (cap_din.size() < nexp)) begin
      n_fail++;
      $display("FAIL %s beat_count: got %0d expected %0d", nm, cap_din.size(), nexp);
    end
    for (int ly = 0; ly < n; ly++)
      for (int lx = 0; lx < n; lx++)
        for (int r = 0; r < s; r++)
          for (int c = 0; c < s; c++) begin
            if (idx < nexp && idx < cap_din.size()) begin
              a  = 14'((ly * s + r) * 128 + lx * s + c);
              ed = ramp_mode ? a[7:0] : img_mem[a];
              ep = {2'(sz), 3'(ly), 3'(lx)};
              if (cap_din[idx] !== ed) begin
                if (md == 0) begin fd = idx; fd_got = cap_din[idx]; fd_exp = ed; end
                md++;
              end
              if (cap_par[idx] !== par_mem[ly * n + lx]) begin
                if (mp == 0) begin fp = idx; fp_got = cap_par[idx]; fp_exp = par_mem[ly * n + lx]; end
                mp++;
              end
              if (cap_pos[idx] !== ep) begin
                if (mc == 0) begin fc = idx; fc_got = cap_pos[idx]; fc_exp = ep; end
                mc++;
              end
            end
            idx++;
          end
    n_checks++;
    if (md != 0) begin
      n_fail++;
      $display("FAIL %s pixel_data: %0d beats differ, first beat %0d got %02h expected %02h", nm, md, fd, fd_got, fd_exp);
    end
    n_checks++;
    if (mp != 0) begin
      n_fail++;
      $display("FAIL %s lcu_params: %0d beats differ, first beat %0d got %06h expected %06h", nm, mp, fp, fp_got, fp_exp);
    end
    n_checks++;
    if (mc != 0) begin
      n_fail++;
      $display("FAIL %s lcu_coords: %0d beats differ, first beat %0d got %02h expected %02h", nm, mc, fc, fc_got, fc_exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, expv);
    end
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    reset = 1'b1; start = 1'b0; busy = 1'b0; cfg_lcu_size = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk) #1;
    outs = {img_rd, img_addr, par_rd, par_addr, in_en, din, ipf_type, ipf_band_pos,
            ipf_wo_class, ipf_offset, lcu_x, lcu_y, lcu_size, done};
    n_checks++;
    if (outs !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %016h expected 0", outs);
    end
    @(posedge clk) #1 reset = 1'b0;
  endtask

  task automatic test_size16_ramp();
    int gaps = 0;
    ramp_mode = 1'b1;
    run_frame(0, 1'b0, -1, 20000);
    check_stream("size16", 0, 16384, 1'b1);
    check_int("size16 done_pulses", done_cnt, 1);
    check_int("size16 beat15", din_at(15), 15);
    check_int("size16 beat16_addr128", din_at(16), 128);
    check_int("size16 lcu1_first_addr16", din_at(256), 16);
    check_int("size16 par_rd_latency", first_par_cyc - start_cyc, 1);
    check_int("size16 img_rd_latency", first_img_cyc - start_cyc, 3);
    check_int("size16 first_beat_latency", cyc_at(0) - start_cyc, 5);
    check_int("size16 lcu_gap", cyc_at(256) - cyc_at(255), 5);
    check_int("size16 done_after_last", done_cyc - cyc_at(16383), 1);
    for (int i = 1; i < 16384; i++)
      if ((i % 256) != 0 && (cyc_at(i) - cyc_at(i - 1)) != 1) gaps++;
    check_int("size16 in_lcu_stalls", gaps, 0);
  endtask

  task automatic test_size64_params();
    int bad = 0;
    ramp_mode = 1'b0;
    run_frame(2, 1'b0, 1000, 20000);
    check_stream("size64", 2, 16384, 1'b1);
    check_int("size64 done_pulses", done_cnt, 1);
    check_int("size64 par_rd_count", par_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i >= par_q.size() || par_q[i] !== 6'(i)) bad++;
    check_int("size64 par_addr_seq_errors", bad, 0);
    bad = 0;
    for (int i = 12288; i < 16384; i++)
      if (i >= cap_par.size() || cap_par[i] !== par_mem[3]) bad++;
    check_int("size64 lcu3_param_unstable_beats", bad, 0);
  endtask

  task automatic test_busy_random();
    ramp_mode = 1'b0;
    run_frame(1, 1'b1, -1, 45000);
    check_stream("busy32", 1, 16384, 1'b1);
    check_int("busy32 in_en_while_busy", busy_viol, 0);
    check_int("busy32 done_pulses", done_cnt, 1);
  endtask

  task automatic test_bad_size();
    clear_mon();
    pulse_start(2'd3);
    repeat (10) @(posedge clk);
    #1;
    check_int("bad_size par_rd", par_rd_cnt, 0);
    check_int("bad_size img_rd", img_rd_cnt, 0);
    check_int("bad_size beats", cap_din.size(), 0);
  endtask

  task automatic test_reset_midframe();
    logic [63:0] outs;
    ramp_mode = 1'b0;
    busy = 1'b0;
    clear_mon();
    pulse_start(2'd0);
    for (int i = 0; i < 2000 && cap_din.size() < 500; i++) @(negedge clk) #1;
    check_int("midreset beats_before_reset", cap_din.size(), 500);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk) #1;
    outs = {img_rd, img_addr, par_rd, par_addr, in_en, din, ipf_type, ipf_band_pos,
            ipf_wo_class, ipf_offset, lcu_x, lcu_y, lcu_size, done};
    n_checks++;
    if (outs !== 64'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %016h expected 0", outs);
    end
    @(posedge clk) #1 reset = 1'b0;
    check_int("midreset no_done", done_cnt, 0);
    clear_mon();
    pulse_start(2'd0);
    for (int i = 0; i < 2000 && cap_din.size() < 300; i++) @(negedge clk) #1;
    check_stream("restart", 0, 300, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; busy = 1'b0; cfg_lcu_size = 2'd0; ramp_mode = 1'b0;
    for (int i = 0; i < 16384; i++) img_mem[i] = 8'($urandom);
    for (int i = 0; i < 64; i++) par_mem[i] = 24'($urandom);
    clear_mon();
    test_reset();
    test_size16_ramp();
    test_size64_params();
    test_busy_random();
    test_bad_size();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ipf_lcu_feeder.md
# ipf_lcu_feeder

Streaming source that drives the IPF pixel-input interface. It reads a 128x128 8-bit frame from an external image ROM and sends it LCU by LCU, raster order inside each LCU, with the per-LCU filter parameters and LCU coordinates. It throttles on the filter's `busy` and pulses `done` after the last pixel of the frame is accepted. It sits between the frame/parameter memories and the IPF core.

## Interface
- `IMG_W`, 128: frame width and height in pixels. Fixed by the 14-bit pixel address.
- `RD_LAT`, 1: image and parameter ROM read latency in cycles. Only 1 is supported.
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that begins a frame. Ignored unless the FSM is in IDLE.
- `cfg_lcu_size` in 2: LCU size, 0=16, 1=32, 2=64. Sampled on `start`. A value of 3 makes the block ignore `start`.
- `img_rd` out 1, `img_addr` out 14: image ROM read request.
- `img_data` in 8: image ROM data, valid one cycle after `img_rd`.
- `par_rd` out 1, `par_addr` out 6: parameter ROM read request, addressed by LCU index.
- `par_data` in 24: parameter word {type[23:22], band_pos[21:17], wo_class[16], offset[15:0]}, valid one cycle after `par_rd`.
- `busy` in 1: IPF is not accepting pixels. Driven from an IPF register.
- `in_en` out 1, `din` out 8: pixel beat.
- `ipf_type` out 2, `ipf_band_pos` out 5, `ipf_wo_class` out 1, `ipf_offset` out 16: current LCU parameters.
- `lcu_x` out 3, `lcu_y` out 3, `lcu_size` out 2: current LCU coordinates and size.
- `done` out 1: one-cycle pulse at frame end.

## Operation
- LCU size S = 16 << `lcu_size`. The frame has N = 8 >> `lcu_size` LCUs per side. LCU index = `lcu_y`*N + `lcu_x`. LCUs are visited in raster order: x fastest, then y.
- Pixel address = (`lcu_y`*S + r)*128 + `lcu_x`*S + c, where r is the row and c the column inside the LCU. c is fastest. Arithmetic is 14-bit with no wrap, because the maximum is 16383.
- FSM states:
  - IDLE: on a valid `start`, latch `lcu_size`, clear x, y, r, c, and go to PARAM.
  - PARAM: issue `par_rd` with `par_addr` = LCU index, go to PLOAD.
  - PLOAD: register `par_data` into the parameter outputs, go to STREAM.
  - STREAM: fetch and send S*S pixels. After the last pixel of the LCU is accepted:
    - If the LCU was (N-1, N-1), go to DONE.
    - Otherwise advance x (wrap to 0 and increment y), go to PARAM.
  - DONE: pulse `done`, return to IDLE.
- Fetch runs only in STREAM. `img_rd` is asserted when (fifo count + in-flight reads − pop this cycle) < 2 and the LCU still has pixels left to fetch. Returning `img_data` is pushed into the 2-entry FIFO.
- `in_en` = (state == STREAM) & fifo non-empty & ~`busy`. This is combinational in `busy`. `din` is the FIFO head, and a pop occurs on `in_en`. While `busy` is high, no beat is sent.
- Parameter and coordinate outputs change only in PLOAD. They are stable during every beat of an LCU.
- Reset values: every output is 0, state is IDLE, the FIFO is empty and in-flight tracking is cleared. A reset mid-frame aborts the frame, and ROM data arriving after reset is discarded. No `done` pulse is produced.
- A `start` pulse outside IDLE has no effect.

## Timing
- `start` in cycle 0 → `par_rd` in cycle 1 → parameters valid in cycle 3 (PLOAD in cycle 2, registered by the edge into cycle 3).
- First `img_rd` in cycle 3. First `in_en` in cycle 5 at the earliest, if `busy` is low.
- With `busy` low, throughput is 1 pixel/cycle inside an LCU.
- The LCU-to-LCU gap is 4 idle `in_en` cycles: PARAM, PLOAD, and FIFO refill.
- `done` is asserted in the cycle after the final beat.
- `busy` rising stalls `in_en` in the same cycle. Pixel order is preserved across any busy pattern.

## Structure
- Shared `ipf_pkg`:
  - `IMG_W`.
  - LCU size encoding and a `lcu_size_t` enum.
  - Parameter-word field positions and widths.
  - The feeder state enum.
- Sub-module `ipf_pix_fifo`: 2-entry, 8-bit synchronous FIFO with push, pop, count, and a simultaneous push+pop allowed when full. The rest is a single FSM plus counters.

## Test plan
- Size 0, `busy` held 0, ROM data = addr[7:0]:
  - 16384 beats.
  - Beats 0..15 carry addresses 0..15. Beat 16 carries address 128.
  - LCU (1,0) starts at address 16.
  - One `done` pulse.
- Size 2, `busy` held 0:
  - 4 LCUs.
  - `par_addr` sequence is 0, 1, 2, 3.
  - The parameter outputs for LCU 3 equal `par_data` word 3 and stay constant over its 4096 beats.
- `busy` random 50% in size 1: the captured pixel stream equals the no-busy stream, with no `in_en` while `busy` is 1.
- `reset` asserted at beat 500:
  - All outputs are 0 the next cycle.
  - A new `start` replays from address 0.
  - No stale pixel appears.
- `start` while STREAM, and `start` with `cfg_lcu_size`=3 in IDLE → no state change, no `par_rd`.
